// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the execute-stage ALU.
//               alu_op_e carries the 4-bit ALUCntl operation codes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int SHAMT_W       = $clog2(WIDTH_DEFAULT);

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_ADDC = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_SLTU = 4'b1010,
        ALU_SUBC = 4'b1011,
        ALU_NOR  = 4'b1100,
        ALU_LUI  = 4'b1101,
        ALU_RSV0 = 4'b1110,
        ALU_RSV1 = 4'b1111
    } alu_op_e;

endpackage
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_if
// Description : Operand/result bundle between the datapath and the ALU.
//               master : drives A, B, ALUCntl, CarryIn; receives results
//               slave  : the ALU side
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUCntl;
    logic             CarryIn;
    logic [WIDTH-1:0] ALUOut;
    logic             Zero;
    logic             CarryOut;
    logic             Overflow;

    modport master (
        output A, B, ALUCntl, CarryIn,
        input  ALUOut, Zero, CarryOut, Overflow
    );

    modport slave (
        input  A, B, ALUCntl, CarryIn,
        output ALUOut, Zero, CarryOut, Overflow
    );
endinterface
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
// Module      : alu_addsub
// Description : WIDTH-bit adder with optional B inversion and selectable
//               carry-in. Shared by every add, subtract and compare op.
//               i_a, i_b      : operands
//               i_invert_b    : add ~B instead of B
//               i_cin         : carry into bit 0
//               o_sum         : WIDTH-bit sum
//               o_carry       : carry out of bit WIDTH-1
//               o_overflow    : two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic             i_invert_b,
    input  wire logic             i_cin,
    output logic      [WIDTH-1:0] o_sum,
    output logic                  o_carry,
    output logic                  o_overflow
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_full;

    always_comb begin
        w_b_eff    = i_invert_b ? ~i_b : i_b;
        w_full     = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_cin};
        o_sum      = w_full[WIDTH-1:0];
        o_carry    = w_full[WIDTH];
        // Overflow judged against the operand actually added (B or ~B).
        o_overflow = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_full[WIDTH-1] != i_a[WIDTH-1]);
    end

endmodule
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Registered 32-bit MIPS execute-stage ALU. Result and the
//               Zero/CarryOut/Overflow flags are computed combinationally
//               and captured on the rising edge (1-cycle latency).
//               clk    : system clock
//               reset  : synchronous active-high, clears all outputs
//               bus    : alu_if slave (A, B, ALUCntl, CarryIn in;
//                        ALUOut, Zero, CarryOut, Overflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_if.slave      bus
);

    localparam int c_shamt_w = $clog2(WIDTH);

    alu_op_e              w_op;
    logic [c_shamt_w-1:0] w_shamt;
    logic                 w_invert_b;
    logic                 w_cin;
    logic                 w_arith;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_carry;
    logic                 w_overflow;
    logic                 w_lt_signed;
    logic                 w_lt_unsigned;
    logic [WIDTH-1:0]     w_result;

    logic [WIDTH-1:0]     r_alu_out;
    logic                 r_zero;
    logic                 r_carry_out;
    logic                 r_overflow;

    assign w_op    = alu_op_e'(bus.ALUCntl);
    assign w_shamt = bus.B[c_shamt_w-1:0];

    // Adder control: compares run as A - B; only ADDC/SUBC consume CarryIn.
    always_comb begin
        w_invert_b = 1'b0;
        w_cin      = 1'b0;
        w_arith    = 1'b0;
        case (w_op)
            ALU_ADD:  begin w_arith = 1'b1; end
            ALU_ADDC: begin w_arith = 1'b1; w_cin = bus.CarryIn; end
            ALU_SUB:  begin w_arith = 1'b1; w_invert_b = 1'b1; w_cin = 1'b1; end
            ALU_SUBC: begin w_arith = 1'b1; w_invert_b = 1'b1; w_cin = bus.CarryIn; end
            ALU_SLT,
            ALU_SLTU: begin w_invert_b = 1'b1; w_cin = 1'b1; end
            default:  begin end
        endcase
    end

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a        (bus.A),
        .i_b        (bus.B),
        .i_invert_b (w_invert_b),
        .i_cin      (w_cin),
        .o_sum      (w_sum),
        .o_carry    (w_carry),
        .o_overflow (w_overflow)
    );

    // Sign of A-B corrected by overflow gives the true signed ordering;
    // a missing carry out of A + ~B + 1 means a borrow, i.e. A < B unsigned.
    assign w_lt_signed   = w_sum[WIDTH-1] ^ w_overflow;
    assign w_lt_unsigned = ~w_carry;

    always_comb begin
        w_result = '0;
        case (w_op)
            ALU_AND:  w_result = bus.A & bus.B;
            ALU_OR:   w_result = bus.A | bus.B;
            ALU_ADD,
            ALU_ADDC,
            ALU_SUB,
            ALU_SUBC: w_result = w_sum;
            ALU_XOR:  w_result = bus.A ^ bus.B;
            ALU_SLL:  w_result = bus.A << w_shamt;
            ALU_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt_signed};
            ALU_SRL:  w_result = bus.A >> w_shamt;
            ALU_SRA:  w_result = $unsigned($signed(bus.A) >>> w_shamt);
            ALU_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_lt_unsigned};
            ALU_NOR:  w_result = ~(bus.A | bus.B);
            ALU_LUI:  w_result = bus.B << 16;
            default:  w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_out   <= '0;
            r_zero      <= 1'b0;   // forced low, not derived from the result
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_alu_out   <= w_result;
            r_zero      <= (w_result == '0);
            r_carry_out <= w_arith & w_carry;
            r_overflow  <= w_arith & w_overflow;
        end
    end

    assign bus.ALUOut   = r_alu_out;
    assign bus.Zero     = r_zero;
    assign bus.CarryOut = r_carry_out;
    assign bus.Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Self-checking directed bench for alu. Inputs are driven 1 time
//               unit after each rising edge and outputs sampled at that point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    alu_if #(.WIDTH(32)) bus ();

    alu #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] res,
                             input logic z, input logic c, input logic v);
        check_value({tag, ".out"}, bus.ALUOut, res);
        check_value({tag, ".zero"}, {31'b0, bus.Zero}, {31'b0, z});
        check_value({tag, ".carry"}, {31'b0, bus.CarryOut}, {31'b0, c});
        check_value({tag, ".ovf"}, {31'b0, bus.Overflow}, {31'b0, v});
    endtask

    // Drive one operation and advance past the capturing edge.
    task automatic step(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin);
        bus.ALUCntl = op;
        bus.A       = a;
        bus.B       = b;
        bus.CarryIn = cin;
        @(posedge clk);
        #1;
    endtask

    // Reference model: {Overflow, CarryOut, Zero, result}.
    function automatic logic [34:0] model(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic cin);
        logic [32:0] s;
        logic [31:0] r;
        logic [31:0] bb;
        logic        c;
        logic        v;
        s = '0; r = '0; c = 1'b0; v = 1'b0; bb = b;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin s = {1'b0, a} + {1'b0, b}; bb = b; end
            4'd3:  begin s = {1'b0, a} + {1'b0, b} + {32'b0, cin}; bb = b; end
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[4:0];
            4'd6:  begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + 33'd1; end
            4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  r = a >> b[4:0];
            4'd9:  r = $unsigned($signed(a) >>> b[4:0]);
            4'd10: r = (a < b) ? 32'd1 : 32'd0;
            4'd11: begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + {32'b0, cin}; end
            4'd12: r = ~(a | b);
            4'd13: r = {b[15:0], 16'h0000};
            default: r = '0;
        endcase
        if (op == 4'd2 || op == 4'd3 || op == 4'd6 || op == 4'd11) begin
            r = s[31:0];
            c = s[32];
            v = (a[31] == bb[31]) && (r[31] != a[31]);
        end
        return {v, c, (r == 32'd0), r};
    endfunction

    initial begin
        logic [34:0] exp_v;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;

        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;

        // Reset with non-zero-producing inputs: everything, Zero included, is 0.
        step(4'b0001, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        step(4'b0001, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);

        reset = 1'b0;
        step(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
        check_all("and", 32'hF000_F000, 1'b0, 1'b0, 1'b0);

        step(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check_all("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        step(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check_all("add_carry", 32'h0, 1'b1, 1'b1, 1'b0);

        step(4'b0110, 32'd5, 32'd5, 1'b0);
        check_all("sub_eq", 32'h0, 1'b1, 1'b1, 1'b0);
        step(4'b0111, 32'h8000_0000, 32'h0000_0001, 1'b0);
        check_all("slt", 32'h1, 1'b0, 1'b0, 1'b0);
        step(4'b1010, 32'h8000_0000, 32'h0000_0001, 1'b0);
        check_all("sltu", 32'h0, 1'b1, 1'b0, 1'b0);

        step(4'b0011, 32'd1, 32'd1, 1'b1);
        check_all("addc", 32'd3, 1'b0, 1'b0, 1'b0);
        // 5 + ~3 + 0 = 1 with carry out (no borrow).
        step(4'b1011, 32'd5, 32'd3, 1'b0);
        check_all("subc", 32'd1, 1'b0, 1'b1, 1'b0);
        step(4'b0010, 32'd1, 32'd1, 1'b1);
        check_all("add_ign_cin", 32'd2, 1'b0, 1'b0, 1'b0);

        // Inputs changed between edges must not reach the outputs.
        bus.ALUCntl = 4'b0100;
        bus.A       = 32'hFFFF_FFFF;
        bus.B       = 32'h0;
        #3;
        check_value("hold.out", bus.ALUOut, 32'd2);

        step(4'b1001, 32'h8000_0000, 32'd4, 1'b0);
        check_all("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        step(4'b1000, 32'h8000_0000, 32'd4, 1'b0);
        check_all("srl", 32'h0800_0000, 1'b0, 1'b0, 1'b0);
        step(4'b0101, 32'd1, 32'd31, 1'b0);
        check_all("sll", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        step(4'b1101, 32'h0, 32'h0000_1234, 1'b0);
        check_all("lui", 32'h1234_0000, 1'b0, 1'b0, 1'b0);
        step(4'b1100, 32'h0F0F_0000, 32'h0000_00F0, 1'b0);
        check_all("nor", 32'hF0F0_FF0F, 1'b0, 1'b0, 1'b0);
        step(4'b1110, 32'hDEAD_BEEF, 32'h1, 1'b1);
        check_all("rsv", 32'h0, 1'b1, 1'b0, 1'b0);

        // Mid-stream reset discards the in-flight result.
        reset = 1'b1;
        step(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check_all("mid_reset", 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Back-to-back: new op every cycle across all codes.
        for (int i = 0; i < 48; i++) begin
            op  = 4'(i % 16);
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom);
            if (i >= 32) b = a;   // exercise equal-operand compares/subs
            exp_v = model(op, a, b, cin);
            step(op, a, b, cin);
            check_all($sformatf("b2b%0d_op%0d", i, op), exp_v[31:0],
                      exp_v[32], exp_v[33], exp_v[34]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
